// File: rtl/systolic_mm_array_if.sv
// Job control, operand stream and result stream of the systolic matrix-multiply engine.
interface systolic_mm_array_if #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 20,
    parameter int KW = 4
);
    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] a_col;
    logic [N*DW-1:0] b_row;
    logic            out_valid;
    logic            out_ready;
    logic [N*AW-1:0] out_row;
    logic            out_last;
    logic            done;

    modport master (
        output start, k_len, in_valid, a_col, b_row, out_ready,
        input  busy, in_ready, out_valid, out_row, out_last, done
    );

    modport slave (
        input  start, k_len, in_valid, a_col, b_row, out_ready,
        output busy, in_ready, out_valid, out_row, out_last, done
    );
endinterface

// File: rtl/systolic_mm_array.sv
// Output-stationary NxN systolic C=A*B, run-time K; first row K+2N-1 cycles after start, stalls hold out_row.
// Optional SA_SATURATE_EN: saturating accumulators instead of modulo-2^AW wrap.
module systolic_mm_array #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 20,
    parameter int KW = 4
) (
    input  logic               clk,
    input  logic               rst,
    systolic_mm_array_if.slave bus
);
    localparam int RW  = $clog2(N);
    localparam int DCW = $clog2(2 * N);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

    state_t         state;
    logic [KW-1:0]  k_cnt;
    logic [KW-1:0]  k_tot;
    logic [DCW-1:0] d_cnt;
    logic [RW-1:0]  row;
    logic           hs;
    logic           clear;
    logic           run;

    logic signed [DW-1:0] a_inj [N];
    logic signed [DW-1:0] b_inj [N];
    logic signed [DW-1:0] a_sr  [N][N];
    logic signed [DW-1:0] b_sr  [N][N];
    logic signed [DW-1:0] a_op  [N][N];
    logic signed [DW-1:0] b_op  [N][N];
    logic signed [DW-1:0] a_h   [N][N];
    logic signed [DW-1:0] b_v   [N][N];
    logic signed [AW-1:0] acc   [N][N];

    assign hs    = bus.in_ready && bus.in_valid;
    assign clear = (state == IDLE) && bus.start;
    assign run   = (state == LOAD) || (state == DRAIN);

    function automatic logic signed [AW-1:0] mac(input logic signed [AW-1:0] sum,
                                                  input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
`ifdef SA_SATURATE_EN
        logic signed [AW:0] s;
        p = a * b;
        s = (AW+1)'(sum) + (AW+1)'(p);
        if (s[AW] != s[AW-1])
            return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        return s[AW-1:0];
`else
        p = a * b;
        return sum + AW'(p);
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            k_cnt         <= '0;
            k_tot         <= '0;
            d_cnt         <= '0;
            row           <= '0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    k_tot    <= bus.k_len;
                    k_cnt    <= '0;
                    d_cnt    <= '0;
                    row      <= '0;
                    bus.busy <= 1'b1;
                    if (bus.k_len == '0) begin
                        state         <= OUT;
                        bus.out_valid <= 1'b1;
                    end else begin
                        state        <= LOAD;
                        bus.in_ready <= 1'b1;
                    end
                end
                LOAD: if (hs) begin
                    k_cnt <= k_cnt + KW'(1);
                    if (k_cnt + KW'(1) == k_tot) begin
                        state        <= DRAIN;
                        bus.in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    // Last PE (N-1,N-1) sees the final beat 2N-2 edges after injection.
                    d_cnt <= d_cnt + DCW'(1);
                    if (d_cnt == DCW'(2 * N - 2)) begin
                        state         <= OUT;
                        bus.out_valid <= 1'b1;
                    end
                end
                OUT: if (bus.out_ready) begin
                    if (row == RW'(N - 1)) begin
                        state         <= IDLE;
                        row           <= '0;
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                    end else begin
                        row          <= row + RW'(1);
                        bus.out_last <= (row + RW'(1) == RW'(N - 1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_inj[i] = hs ? bus.a_col[i*DW +: DW] : '0;
            b_inj[i] = hs ? bus.b_row[i*DW +: DW] : '0;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0)
                    a_op[i][j] = (i == 0) ? a_inj[i] : a_sr[i][(i > 0) ? i - 1 : 0];
                else
                    a_op[i][j] = a_h[i][(j > 0) ? j - 1 : 0];
                if (i == 0)
                    b_op[i][j] = (j == 0) ? b_inj[j] : b_sr[j][(j > 0) ? j - 1 : 0];
                else
                    b_op[i][j] = b_v[(i > 0) ? i - 1 : 0][j];
            end
        end
    end

    // Bubbles keep shifting during LOAD so the skew stays aligned across gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_sr[i][j] <= '0;
                    b_sr[i][j] <= '0;
                    a_h[i][j]  <= '0;
                    b_v[i][j]  <= '0;
                    acc[i][j]  <= '0;
                end
            end
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_sr[i][j] <= '0;
                    b_sr[i][j] <= '0;
                    a_h[i][j]  <= '0;
                    b_v[i][j]  <= '0;
                    acc[i][j]  <= '0;
                end
            end
        end else if (run) begin
            for (int i = 0; i < N; i++) begin
                a_sr[i][0] <= a_inj[i];
                b_sr[i][0] <= b_inj[i];
                for (int d = 1; d < N; d++) begin
                    a_sr[i][d] <= a_sr[i][d-1];
                    b_sr[i][d] <= b_sr[i][d-1];
                end
                for (int j = 0; j < N; j++) begin
                    a_h[i][j] <= a_op[i][j];
                    b_v[i][j] <= b_op[i][j];
                    acc[i][j] <= mac(acc[i][j], a_op[i][j], b_op[i][j]);
                end
            end
        end
    end

    always_comb begin
        bus.out_row = '0;
        for (int j = 0; j < N; j++)
            bus.out_row[j*AW +: AW] = acc[row][j];
    end
endmodule

// File: tb/tb_systolic_mm_array.sv
// Directed and randomized jobs checked against a plain matrix-product reference model.
module tb_systolic_mm_array;
    localparam int N    = 2;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int KW   = 4;
    localparam int KMAX = 15;
    localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (AW - 1));

    logic clk = 1'b0;
    logic rst = 1'b1;

    systolic_mm_array_if #(.N(N), .DW(DW), .AW(AW), .KW(KW)) bus ();

    systolic_mm_array #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int a_m [N][KMAX];
    int b_m [KMAX][N];

    task automatic check(input string tag, input logic [N*AW-1:0] obs, input logic [N*AW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Row r of A*B over the first k terms, accumulated in k order.
    function automatic logic [N*AW-1:0] model_row(input int r, input int k);
        logic [N*AW-1:0] res;
        longint s;
        res = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) begin
                s = s + longint'(a_m[r][kk]) * longint'(b_m[kk][j]);
`ifdef SA_SATURATE_EN
                if (s > MAXV) s = MAXV;
                else if (s < MINV) s = MINV;
`endif
            end
            res[j*AW +: AW] = AW'(s);
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand(input int k);
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < N; i++) begin
                a_m[i][kk] = int'($urandom_range(0, 255)) - 128;
                b_m[kk][i] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic begin_job(input int k);
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic feed(input int k, input bit gaps, output int edges);
        int  sent = 0;
        bit  acc_beat;
        edges = 0;
        while (sent < k && edges < 200) begin
            bus.in_valid = gaps ? edges[0] : 1'b1;
            for (int i = 0; i < N; i++) begin
                bus.a_col[i*DW +: DW] = bus.in_valid ? DW'(a_m[i][sent]) : DW'($urandom);
                bus.b_row[i*DW +: DW] = bus.in_valid ? DW'(b_m[sent][i]) : DW'($urandom);
            end
            acc_beat = bus.in_valid && bus.in_ready;
            tick();
            edges++;
            if (acc_beat) sent++;
        end
        bus.in_valid = 1'b0;
        check_int("feed_beats", sent, k);
    endtask

    task automatic collect(input int k, input bit stall, input bit poke, output int wait_edges);
        logic [N*AW-1:0] held;
        int guard;
        wait_edges = 0;
        bus.in_valid = 1'b1;
        bus.a_col    = N*DW'($urandom);
        bus.b_row    = N*DW'($urandom);
        for (int r = 0; r < N; r++) begin
            guard = 0;
            while (!bus.out_valid && guard < 100) begin
                tick();
                guard++;
            end
            if (r == 0) wait_edges = guard;
            check_bit($sformatf("out_valid_r%0d", r), bus.out_valid, 1'b1);
            bus.in_valid = 1'b0;
            if (poke && r == 0) begin
                bus.start = 1'b1;
                bus.k_len = KW'(5);
            end
            if (stall) begin
                held = bus.out_row;
                repeat (3) begin
                    tick();
                    check("stall_row_stable", bus.out_row, held);
                    check_bit("stall_valid_held", bus.out_valid, 1'b1);
                end
            end
            check($sformatf("row%0d", r), bus.out_row, model_row(r, k));
            check_bit($sformatf("last_r%0d", r), bus.out_last, (r == N - 1));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            bus.start     = 1'b0;
        end
        check_bit("done_pulse", bus.done, 1'b1);
        check_bit("busy_after_done", bus.busy, 1'b0);
        tick();
        check_bit("done_one_cycle", bus.done, 1'b0);
        check_bit("still_idle", bus.busy, 1'b0);
    endtask

    task automatic job(input int k, input bit gaps, input bit stall, input bit poke);
        int e;
        int w;
        begin_job(k);
        check_bit("in_ready_after_start", bus.in_ready, (k != 0));
        check_bit("busy_after_start", bus.busy, 1'b1);
        feed(k, gaps, e);
        collect(k, stall, poke, w);
        if (!gaps) check_int($sformatf("latency_k%0d", k), e + w, (k == 0) ? 0 : k + 2 * N - 1);
    endtask

    initial begin
        int  e;
        bit  done_seen;
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.in_valid  = 1'b0;
        bus.a_col     = '0;
        bus.b_row     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_busy", bus.busy, 1'b0);
        check_bit("rst_in_ready", bus.in_ready, 1'b0);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_bit("rst_out_last", bus.out_last, 1'b0);
        check_bit("rst_done", bus.done, 1'b0);
        check("rst_out_row", bus.out_row, '0);
        rst = 1'b0;
        tick();

        // Identity: A=[[1,2],[3,4]], B=I
        a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
        b_m[0][0] = 1; b_m[0][1] = 0; b_m[1][0] = 0; b_m[1][1] = 1;
        job(2, 1'b0, 1'b0, 1'b0);

        // Signed single beat: C00 = -15
        a_m[0][0] = -3; a_m[1][0] = 0;
        b_m[0][0] = 5;  b_m[0][1] = 0;
        job(1, 1'b0, 1'b0, 1'b0);

        // Same data gap-free, then with input gaps and output stalls
        set_rand(3);
        job(3, 1'b0, 1'b0, 1'b0);
        job(3, 1'b1, 1'b1, 1'b0);

        // Overflow: 15 terms of 127*127
        for (int kk = 0; kk < KMAX; kk++)
            for (int i = 0; i < N; i++) begin
                a_m[i][kk] = 127;
                b_m[kk][i] = 127;
            end
        job(15, 1'b0, 1'b0, 1'b0);

        // Abort after 2 of 3 beats
        set_rand(3);
        begin_job(3);
        feed(2, 1'b0, e);
        #2 rst = 1'b1;
        #1;
        check_bit("abort_busy", bus.busy, 1'b0);
        check_bit("abort_in_ready", bus.in_ready, 1'b0);
        check("abort_row_cleared", bus.out_row, '0);
        tick();
        rst = 1'b0;
        done_seen = 1'b0;
        repeat (6) begin
            tick();
            done_seen = done_seen | bus.done;
        end
        check_bit("abort_no_done", done_seen, 1'b0);
        check_bit("abort_no_valid", bus.out_valid, 1'b0);
        set_rand(3);
        job(3, 1'b0, 1'b0, 1'b0);

        // k_len = 0 after a nonzero job, then start poked during OUT
        job(0, 1'b0, 1'b0, 1'b0);
        set_rand(4);
        job(4, 1'b0, 1'b1, 1'b1);

        for (int t = 0; t < 6; t++) begin
            int k;
            k = int'($urandom_range(1, KMAX));
            set_rand(k);
            job(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
